// File: rtl/fpga_clock_top.sv
// -----------------------------------------------------------------------------
// fpga_clock_top
// 24-hour HH:MM digital clock: 1 s prescaler, two debounced push buttons,
// mode FSM for time setting, BCD time counters and a 4-digit multiplexed
// 7-segment scanner.
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset_n     asynchronous active-low reset
//   i_Button_Set  mode button (active high, raw/bouncy)
//   i_Button_Up   increment button (active high, raw/bouncy)
//   o_Segments    {dot, g, f, e, d, c, b, a}, active high, registered
//   o_Digits      one-hot digit select {hour tens, hour units, min tens,
//                 min units}, active high, registered
// -----------------------------------------------------------------------------
module fpga_clock_top #(
    parameter int TICKS_PER_SEC   = 32768,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int MUX_CYCLES      = 32
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Button_Set,
    input  logic       i_Button_Up,
    output logic [7:0] o_Segments,
    output logic [3:0] o_Digits
);

    localparam int PW = (TICKS_PER_SEC > 1)   ? $clog2(TICKS_PER_SEC)   : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MW = (MUX_CYCLES > 1)      ? $clog2(MUX_CYCLES)      : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MW-1:0] SCAN_LAST  = MW'(MUX_CYCLES - 1);

    typedef enum logic [1:0] {NORMAL, SET_ENTRY, SET_MIN, SET_HOUR} mode_t;

    // Button index 0 = Set, 1 = Up
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    level_q, level_d, press_q, press_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [3:0]    min_u_q, min_u_d;
    logic [2:0]    min_t_q, min_t_d;
    logic [3:0]    hr_u_q, hr_u_d;
    logic [1:0]    hr_t_q, hr_t_d;
    logic          min_carry;
    logic          set_p, up_p;

    logic [MW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [3:0]    digits_q, digits_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    bcd;
    logic          dot;

    // Returns {carry, tens, units} of minutes + 1
    function automatic logic [7:0] min_inc(input logic [2:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 3'd5) return {1'b1, 3'd0, 4'd0};
            return {1'b0, t + 3'd1, 4'd0};
        end
        return {1'b0, t, u + 4'd1};
    endfunction

    // Returns {tens, units} of (hours + 1) mod 24
    function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3) return 6'd0;
        if (u == 4'd9)              return {t + 2'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    // BCD to segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Debounce: the accepted level flips only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreeing cycle clears the count.
    always_comb begin
        sync1_d   = {i_Button_Up, i_Button_Set};
        sync2_d   = sync1_q;
        level_d   = level_q;
        deb_cnt_d = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) level_d[i] = sync2_q[i];
                else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // Mode FSM and timekeeping
    always_comb begin
        mode_d    = mode_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        min_u_d   = min_u_q;
        min_t_d   = min_t_q;
        hr_u_d    = hr_u_q;
        hr_t_d    = hr_t_q;
        min_carry = 1'b0;
        set_p     = press_q[0];
        up_p      = press_q[1] & ~press_q[0];   // Set wins a same-cycle clash

        case (mode_q)
            NORMAL: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        {min_carry, min_t_d, min_u_d} = min_inc(min_t_q, min_u_q);
                        if (min_carry) {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (set_p) mode_d = SET_ENTRY;
            end
            SET_ENTRY: begin
                // Seconds and prescaler stay cleared through the setting
                // modes so counting resumes from :00 on return to NORMAL.
                presc_d = '0;
                sec_d   = 6'd0;
                if (set_p) mode_d = SET_MIN;
            end
            SET_MIN: begin
                if (set_p)     mode_d = SET_HOUR;
                else if (up_p) {min_carry, min_t_d, min_u_d} = min_inc(min_t_q, min_u_q);
            end
            default: begin
                if (set_p)     mode_d = NORMAL;
                else if (up_p) {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
            end
        endcase
    end

    // Display scanner; outputs are built from next-state values so the
    // registered segment pattern always belongs to the registered digit.
    always_comb begin
        scan_cnt_d = scan_cnt_q + MW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
        case (scan_idx_d)
            2'd0:    begin digits_d = 4'b1000; bcd = {2'b00, hr_t_d}; dot = 1'b0; end
            2'd1:    begin digits_d = 4'b0100; bcd = hr_u_d;          dot = 1'b1; end
            2'd2:    begin digits_d = 4'b0010; bcd = {1'b0, min_t_d}; dot = 1'b0; end
            default: begin digits_d = 4'b0001; bcd = min_u_d;         dot = 1'b0; end
        endcase
        seg_d = {dot, seg_decode(bcd)};
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            press_q    <= '0;
            deb_cnt_q  <= '{default: '0};
            mode_q     <= NORMAL;
            presc_q    <= '0;
            sec_q      <= '0;
            min_u_q    <= '0;
            min_t_q    <= '0;
            hr_u_q     <= '0;
            hr_t_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= 2'd0;
            digits_q   <= 4'b1000;
            seg_q      <= 8'b0011_1111;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            press_q    <= press_d;
            deb_cnt_q  <= deb_cnt_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_u_q    <= min_u_d;
            min_t_q    <= min_t_d;
            hr_u_q     <= hr_u_d;
            hr_t_q     <= hr_t_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            digits_q   <= digits_d;
            seg_q      <= seg_d;
        end
    end

    assign o_Segments = seg_q;
    assign o_Digits   = digits_q;

endmodule

// File: tb/tb_fpga_clock_top.sv
// -----------------------------------------------------------------------------
// tb_fpga_clock_top
// Directed bench for fpga_clock_top with shortened timing parameters
// (4 cycles per second, 8-cycle debounce, 4-cycle digit dwell).
// -----------------------------------------------------------------------------
module tb_fpga_clock_top;

    localparam int TPS = 4;
    localparam int DEB = 8;
    localparam int MUX = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_up  = 1'b0;
    logic [7:0] seg;
    logic [3:0] dig;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    int unsigned rel    = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    fpga_clock_top #(
        .TICKS_PER_SEC  (TPS),
        .DEBOUNCE_CYCLES(DEB),
        .MUX_CYCLES     (MUX)
    ) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Button_Set(btn_set),
        .i_Button_Up (btn_up),
        .o_Segments  (seg),
        .o_Digits    (dig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a digit to be selected, then check select and pattern.
    task automatic check_digit(input string tag, input logic [3:0] sel, input int val, input logic dot);
        int waited = 0;
        while (dig !== sel && waited < 3 * 4 * MUX) begin
            @(negedge clk);
            waited++;
        end
        check8({tag, "_sel"}, {4'b0, dig}, {4'b0, sel});
        check8(tag, seg, {dot, seg_tab[val]});
    endtask

    task automatic check_time(input string tag, input int hh, input int mm);
        check_digit({tag, "_h10"}, 4'b1000, hh / 10, 1'b0);
        check_digit({tag, "_h1"},  4'b0100, hh % 10, 1'b1);
        check_digit({tag, "_m10"}, 4'b0010, mm / 10, 1'b0);
        check_digit({tag, "_m1"},  4'b0001, mm % 10, 1'b0);
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) btn_up = v;
        else       btn_set = v;
    endtask

    task automatic press(input bit which, input int n);
        for (int k = 0; k < n; k++) begin
            drive(which, 1'b1);
            repeat (DEB + 6) @(negedge clk);
            drive(which, 1'b0);
            repeat (DEB + 6) @(negedge clk);
        end
    endtask

    task automatic glitch(input bit which, input int len);
        drive(which, 1'b1);
        repeat (len) @(negedge clk);
        drive(which, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc - rel < n) @(negedge clk);
    endtask

    initial begin
        int glen [4] = '{5, 3, 2, 1};

        // Power-up reset, then reassert mid-scan
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check8("rst_digits", {4'b0, dig}, 8'b0000_1000);
        check8("rst_seg", seg, 8'b0011_1111);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;

        // Scan walk after release
        wait_until(2);  check8("walk0_dig", {4'b0, dig}, 8'b0000_1000); check8("walk0_seg", seg, 8'b0011_1111);
        wait_until(5);  check8("walk1_dig", {4'b0, dig}, 8'b0000_0100); check8("walk1_seg", seg, 8'b1011_1111);
        wait_until(9);  check8("walk2_dig", {4'b0, dig}, 8'b0000_0010); check8("walk2_seg", seg, 8'b0011_1111);
        wait_until(13); check8("walk3_dig", {4'b0, dig}, 8'b0000_0001); check8("walk3_seg", seg, 8'b0011_1111);
        wait_until(17); check8("walk4_dig", {4'b0, dig}, 8'b0000_1000); check8("walk4_seg", seg, 8'b0011_1111);

        // Short glitches must not change mode (time keeps running)
        for (int g = 0; g < 4; g++) begin
            glitch(1'b0, glen[g]);
            glitch(1'b1, glen[g]);
        end
        for (int g = 0; g < 10; g++) begin
            btn_set = 1'b1; repeat (5) @(negedge clk);
            btn_set = 1'b0; repeat (5) @(negedge clk);
        end

        // Free run: 60 s and 3600 s
        wait_until(60 * TPS + 10);
        check_time("run_0001", 0, 1);
        wait_until(3600 * TPS + 10);
        check_time("run_0100", 1, 0);

        // One held press = exactly one mode advance; SET_ENTRY freezes, ignores Up
        press(1'b0, 1);
        repeat (300) @(negedge clk);
        check_time("entry_frozen", 1, 0);
        press(1'b1, 2);
        press(1'b0, 1);
        press(1'b1, 1);
        check_time("one_advance", 1, 1);

        // Fresh reset, set 12:34
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press(1'b0, 2);
        press(1'b1, 34);
        press(1'b0, 1);
        press(1'b1, 12);
        check_time("set_1234", 12, 34);
        press(1'b0, 1);
        check_time("resume_1234", 12, 34);
        repeat (60 * TPS) @(negedge clk);
        check_time("resume_1235", 12, 35);

        // Minute and hour wraps in setting modes
        press(1'b0, 2);
        press(1'b1, 24);
        check_time("min_59", 12, 59);
        press(1'b1, 1);
        check_time("min_wrap", 12, 0);
        press(1'b1, 59);
        press(1'b0, 1);
        press(1'b1, 11);
        check_time("hour_23", 23, 59);
        press(1'b1, 1);
        check_time("hour_wrap", 0, 59);
        press(1'b1, 23);

        // Midnight rollover
        press(1'b0, 1);
        check_time("pre_midnight", 23, 59);
        repeat (60 * TPS) @(negedge clk);
        check_time("midnight", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
